// File: rtl/shift_add_multiplier_pkg.sv
// Shared multiplier definitions: FSM state encoding and the default datapath width.
package shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder_nbit.sv
// Combinational WIDTH-bit adder with carry-out; zero latency, no flow control.
module adder_nbit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/shift_add_multiplier.sv
// Shift-and-add multiplier, signed/unsigned; result WIDTH+1 cycles after an accepted Start.
// Start is only accepted in IDLE or DONE; requests while busy are dropped.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Sinal,
    input  logic [WIDTH-1:0]     OperandoA,
    input  logic [WIDTH-1:0]     OperandoB,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Pronto,
    output logic                 Ocupado
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int P_W   = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [P_W-1:0]     produto_q, produto_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     partial;

    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic            is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    adder_nbit #(.WIDTH(WIDTH)) u_acc_adder (
        .a_i   (acc_q[P_W-1:WIDTH]),
        .b_i   (mcand_q),
        .sum_o (sum)
    );

    assign partial = mplier_q[0] ? sum : {1'b0, acc_q[P_W-1:WIDTH]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        produto_d = produto_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = CALC;
                    mcand_d  = magnitude(OperandoA, Sinal);
                    mplier_d = magnitude(OperandoB, Sinal);
                    neg_d    = Sinal & (OperandoA[WIDTH-1] ^ OperandoB[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Carry out of the adder becomes the new accumulator MSB after the shift.
                acc_d    = {partial, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                produto_d = neg_q ? (~acc_q + P_W'(1)) : acc_q;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            produto_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            produto_q <= produto_d;
        end
    end

    assign Produto = produto_q;
    assign Pronto  = (state_q == DONE);
    assign Ocupado = (state_q == CALC) || (state_q == SIGN);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed bench for shift_add_multiplier against a transaction-level model.
module tb_shift_add_multiplier;

    localparam int W = 16;

    logic           Clk;
    logic           Reset;
    logic           Start;
    logic           Sinal;
    logic [W-1:0]   OperandoA;
    logic [W-1:0]   OperandoB;
    logic [2*W-1:0] Produto;
    logic           Pronto;
    logic           Ocupado;

    int total = 0;
    int bad   = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Sinal     (Sinal),
        .OperandoA (OperandoA),
        .OperandoB (OperandoB),
        .Produto   (Produto),
        .Pronto    (Pronto),
        .Ocupado   (Ocupado)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference product modulo 2^(2W) from extended operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Transaction model: a request is taken when nothing is pending; its result lands W+1 edges later.
    logic           m_valid = 1'b0;
    logic           m_pend  = 1'b0;
    logic           m_pronto = 1'b0;
    logic [2*W-1:0] m_prod  = '0;
    logic [2*W-1:0] m_next  = '0;
    int             m_left  = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid  = 1'b1;
            m_pend   = 1'b0;
            m_pronto = 1'b0;
            m_prod   = '0;
        end else begin
            m_pronto = 1'b0;
            if (!m_pend) begin
                if (Start) begin
                    m_pend = 1'b1;
                    m_left = W + 1;
                    m_next = ref_mul(OperandoA, OperandoB, Sinal);
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_pend   = 1'b0;
                    m_prod   = m_next;
                    m_pronto = 1'b1;
                end
            end
        end
    end

    int cyc = 0;
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (m_valid) begin
            total = total + 1;
            if (Produto !== m_prod || Pronto !== m_pronto || Ocupado !== m_pend) begin
                bad = bad + 1;
                $display("FAIL model_cmp cyc=%0d got prod=%h pronto=%b ocup=%b exp prod=%h pronto=%b ocup=%b",
                         cyc, Produto, Pronto, Ocupado, m_prod, m_pronto, m_pend);
            end
        end
    end

    task automatic check(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic wait_pronto(output int cnt);
        cnt = 0;
        forever begin
            @(negedge Clk);
            cnt = cnt + 1;
            if (Pronto === 1'b1) return;
            if (cnt > 100) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL pronto_timeout waited=%0d limit=100", cnt);
                return;
            end
        end
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge Clk);
        #1;
        Start     = 1'b1;
        OperandoA = a;
        OperandoB = b;
        Sinal     = s;
    endtask

    // Directed op: operands are scrambled right after acceptance and must not matter.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] expv, input string nm);
        int cnt;
        drive_start(a, b, s);
        @(negedge Clk);
        #1;
        Start     = 1'b0;
        OperandoA = W'($urandom);
        OperandoB = W'($urandom);
        Sinal     = 1'($urandom);
        wait_pronto(cnt);
        check(nm, Produto, expv);
        check({nm, "_latency"}, 2*W'(cnt), 2*W'(W + 1));
    endtask

    initial begin
        int cnt;
        int pronto_seen;
        Reset     = 1'b1;
        Start     = 1'b0;
        Sinal     = 1'b0;
        OperandoA = '0;
        OperandoB = '0;
        repeat (3) @(negedge Clk);
        check("reset_produto", Produto, '0);
        check("reset_flags", {30'd0, Pronto, Ocupado}, 32'd0);
        #1;
        Reset = 1'b0;

        do_op(16'd10,   16'd20,   1'b0, 32'd200,        "u_10x20");
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001,   "u_ffff_sq");
        do_op(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF0001,   "u_7fff_sq");
        do_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1,   "s_m3x5");
        do_op(16'h8000, 16'h8000, 1'b1, 32'h40000000,   "s_min_sq");
        do_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000,   "s_max_x_min");
        do_op(16'h0000, 16'hFFFF, 1'b1, 32'h00000000,   "s_zero");
        do_op(16'h8000, 16'h0003, 1'b0, 32'h00018000,   "u_8000x3");

        // Start pulse with new operands during CALC must be ignored.
        drive_start(16'd100, 16'd7, 1'b0);
        @(negedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        #1;
        Start = 1'b1; OperandoA = 16'd9; OperandoB = 16'd9;
        @(negedge Clk);
        #1;
        Start = 1'b0;
        wait_pronto(cnt);
        check("ignore_midcalc_start", Produto, 32'd700);

        // Reset in the middle of CALC abandons the operation.
        drive_start(16'h1234, 16'h0056, 1'b0);
        @(negedge Clk);
        #1;
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset_produto", Produto, '0);
        check("midreset_ocupado", {31'd0, Ocupado}, 32'd0);
        #1;
        Reset = 1'b0;
        pronto_seen = 0;
        repeat (25) begin
            @(negedge Clk);
            if (Pronto === 1'b1) pronto_seen = pronto_seen + 1;
        end
        check("midreset_no_pronto", 2*W'(pronto_seen), '0);
        do_op(16'd2, 16'd3, 1'b0, 32'd6, "after_reset_2x3");

        // Start held high through DONE: second op follows with no bubble.
        drive_start(16'd300, 16'd11, 1'b0);
        @(negedge Clk);
        #1;
        OperandoA = 16'hFFFE; OperandoB = 16'h0004; Sinal = 1'b1;
        wait_pronto(cnt);
        check("b2b_first", Produto, 32'd3300);
        check("b2b_first_latency", 2*W'(cnt), 2*W'(W + 1));
        @(negedge Clk);
        #1;
        Start = 1'b0;
        wait_pronto(cnt);
        check("b2b_second", Produto, 32'hFFFFFFF8);
        check("b2b_second_latency", 2*W'(cnt), 2*W'(W + 1));

        // Random operations with stray Start pulses while busy.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            if (n % 8 == 0) a = 16'h8000;
            if (n % 11 == 0) b = 16'h0000;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            drive_start(a, b, s);
            @(negedge Clk);
            #1;
            for (int k = 1; k < W; k++) begin
                Start     = 1'($urandom);
                OperandoA = W'($urandom);
                OperandoB = W'($urandom);
                Sinal     = 1'($urandom);
                @(negedge Clk);
                #1;
            end
            Start = 1'b0;
            wait_pronto(cnt);
            check("rand_product", Produto, ref_mul(a, b, s));
        end

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
